turf_event_fragmenter: RTL and testbench
========================================

Name: turf_event_fragmenter

Overview:
- Downstream consumer of the event control port's configuration outputs: event IP/port/open, fragment length and fragment source mask.
- Takes complete events (a length word plus a 64-bit data stream) and splits each event into UDP fragments addressed to the open event destination.
- Output feeds the UDP transmit mux through the standard 64-bit IP/port/length header stream and data stream.
- Drops events when the event port is closed; counts sent, dropped and malformed events.

Parameters:
- EVLEN_BITS, 20: width of the event byte length (maximum event size is 2^20-1 bytes).
- DEBUG, "FALSE": "TRUE" instantiates an ILA on the handshakes and state.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- s_evlen_tdata/tvalid/tready  in/in/out  EVLEN_BITS/1/1  event length in bytes, one beat per event.
- s_evdata_tdata/tkeep/tlast/tvalid/tready  in/in/in/in/out  64/8/1/1/1  event payload; tlast on the final word.
- m_udphdr_tdata/tvalid/tready  out/out/in  64/1/1  {ip[63:32], port[31:16], udp_len[15:0]}.
- m_udpdata_tdata/tkeep/tlast/tvalid/tready  out/out/out/out/in  64/8/1/1/1  fragment payload.
- nfragment_count_i  in  10  payload words per fragment minus 1.
- fragsrc_mask_i  in  16  copied into the fragment header [15:0] of fragment 0 only.
- event_ip_i  in  32  event destination IP.
- event_port_i  in  16  event destination port.
- event_open_i  in  1  event destination open.
- event_count_o  out  32  events sent.
- drop_count_o  out  16  events dropped.
- err_count_o  out  16  events with a length/tlast mismatch or zero length.

Behaviour:
- Reset: all tvalid/tready low, state IDLE, all counters 0, event number 0.
- States:
  - IDLE: s_evlen_tready=1. On a handshake, latch len, ip, port, open, nfrag and mask; go to CHECK.
  - CHECK: if !open or len==0 -> DROP. len==0 also increments err_count. Otherwise rem_bytes=len, frag_idx=0 -> CALC.
  - CALC (1 cycle):
    - maxb = (nfrag+1)*8.
    - fbytes = min(rem_bytes, maxb); last = (rem_bytes <= maxb).
    - fwords = ceil(fbytes/8).
  - HDR: m_udphdr_tvalid=1, udp_len = fbytes+16 (8-byte UDP header plus 8-byte fragment header). Advance on tready.
  - FHDR: m_udpdata_tvalid=1, tkeep=FF, tlast=0.
    - Word = {evnum[63:32], frag_idx[31:16], frag_idx==0 ? mask[15:0] : {15'b0,last}}.
    - On frag_idx==0 the last flag lives in fhdr[0] only when mask[0] is unused; bit 0 of fragment 0 is always mask[0]. Receivers infer the end of an event from fbytes.
    - Advance on tready.
  - DATA: s_evdata_tready = m_udpdata_tready; m_udpdata_tvalid = s_evdata_tvalid; word counter counts to fwords.
    - tkeep = input tkeep on the final word of the event, FF otherwise.
    - tlast on the final word of the fragment.
    - After the final word: if last, increment event_count and evnum and go to IDLE. Otherwise rem_bytes -= maxb, frag_idx++, go to CALC.
  - DROP: s_evdata_tready=1 and discard until a tlast handshake. Increment drop_count (unless the entry was via ERR) -> IDLE.
- Mismatches:
  - Input tlast before the expected final event word: emit that word with m tlast=1, increment err_count, go to IDLE. evnum still increments.
  - Expected final event word without input tlast: emit it with tlast, increment err_count -> DROP (no drop_count increment).
- Configuration is latched per event. Changes to event_open_i, ip or port mid-event do not affect the event in flight.
- Counters saturate at all-ones; evnum wraps at 2^32.
- Latency: the first m_udphdr_tvalid is 3 cycles after the s_evlen handshake.
- No combinational path from m_udphdr_tready to s_evlen_tready.
- Reset mid-operation: abandons the fragment with no tlast. Upstream and downstream are reset together.

Decomposition:
- Package turf_event_pkg:
  - FSM state enum.
  - Fragment header field offsets.
  - UDP_HDR_BYTES=8 and FRAG_HDR_BYTES=8.
  - Header tdata field offsets, shared with the control port.
- Sub-module turf_frag_calc: combinational min/ceil/last computation, registered in CALC.

Test Plan:
- open=1, nfrag=127, len=2048 -> 2 fragments, each udp_len=1040 with 128 data words; frag_idx 0,1; last bit set on fragment 1; event_count=1.
- len=1029, nfrag=127 -> fragment 0 udp_len=1040; fragment 1 udp_len=21 with 1 data word, tkeep=0x1F, tlast.
- open=0, 4-word event -> no m_udphdr_tvalid; all 4 words consumed; drop_count=1.
- len=64 but input tlast on word 5 -> 5 words out, tlast on word 5, err_count=1, evnum=1. Next event is processed normally.
- Random m tready stalls (50%) on a 3000-byte event with nfrag=31 -> 12 fragments, byte-exact payload, no lost or duplicated words.
- event_open_i deasserted mid-event -> current event completes; the next event is dropped.

Source files
------------

// File: rtl/turf_event_pkg.sv
// Shared types and header field layout for the event fragmenter.
// The header offsets are also used by the event control port.
package turf_event_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_CALC,
    ST_HDR,
    ST_FHDR,
    ST_DATA,
    ST_DROP
  } state_t;

  localparam int UDP_HDR_BYTES  = 8;
  localparam int FRAG_HDR_BYTES = 8;

  localparam int HDR_IP_LSB     = 32;
  localparam int HDR_PORT_LSB   = 16;
  localparam int HDR_LEN_LSB    = 0;

  localparam int FHDR_EVNUM_LSB = 32;
  localparam int FHDR_IDX_LSB   = 16;
  localparam int FHDR_FLAG_LSB  = 0;

  function automatic logic [63:0] udp_hdr_word(input logic [31:0] ip,
                                               input logic [15:0] port,
                                               input logic [15:0] len);
    logic [63:0] w;
    w = '0;
    w[HDR_IP_LSB +: 32]   = ip;
    w[HDR_PORT_LSB +: 16] = port;
    w[HDR_LEN_LSB +: 16]  = len;
    return w;
  endfunction

  function automatic logic [63:0] frag_hdr_word(input logic [31:0] evnum,
                                                input logic [15:0] idx,
                                                input logic [15:0] flags);
    logic [63:0] w;
    w = '0;
    w[FHDR_EVNUM_LSB +: 32] = evnum;
    w[FHDR_IDX_LSB +: 16]   = idx;
    w[FHDR_FLAG_LSB +: 16]  = flags;
    return w;
  endfunction

endpackage

// File: rtl/turf_frag_calc.sv
// Sizes the next fragment from the bytes still owed for the event.
// Purely combinational; the parent registers the results in its CALC state.
module turf_frag_calc #(
  parameter int EVLEN_BITS = 20
) (
  input  logic [EVLEN_BITS-1:0] rem_bytes,
  input  logic [9:0]            nfrag,
  output logic [13:0]           maxb,
  output logic [13:0]           fbytes,
  output logic [10:0]           fwords,
  output logic                  last
);

  logic [10:0] max_words;
  logic [13:0] fbytes_rnd;

  always_comb begin
    max_words  = {1'b0, nfrag} + 11'd1;
    maxb       = {max_words, 3'b000};
    last       = (32'(rem_bytes) <= 32'(maxb));
    // when last is set the remainder fits in maxb, so truncation is safe
    fbytes     = last ? 14'(rem_bytes) : maxb;
    fbytes_rnd = fbytes + 14'd7;
    fwords     = fbytes_rnd[13:3];
  end

endmodule

// File: rtl/turf_event_fragmenter.sv
// Splits length-prefixed events into UDP fragments for the open event destination,
// dropping events while closed and counting sent, dropped and malformed events.
module turf_event_fragmenter
  import turf_event_pkg::*;
#(
  parameter int    EVLEN_BITS = 20,
  parameter string DEBUG      = "FALSE"
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [EVLEN_BITS-1:0] s_evlen_tdata,
  input  logic                  s_evlen_tvalid,
  output logic                  s_evlen_tready,
  input  logic [63:0]           s_evdata_tdata,
  input  logic [7:0]            s_evdata_tkeep,
  input  logic                  s_evdata_tlast,
  input  logic                  s_evdata_tvalid,
  output logic                  s_evdata_tready,
  output logic [63:0]           m_udphdr_tdata,
  output logic                  m_udphdr_tvalid,
  input  logic                  m_udphdr_tready,
  output logic [63:0]           m_udpdata_tdata,
  output logic [7:0]            m_udpdata_tkeep,
  output logic                  m_udpdata_tlast,
  output logic                  m_udpdata_tvalid,
  input  logic                  m_udpdata_tready,
  input  logic [9:0]            nfragment_count_i,
  input  logic [15:0]           fragsrc_mask_i,
  input  logic [31:0]           event_ip_i,
  input  logic [15:0]           event_port_i,
  input  logic                  event_open_i,
  output logic [31:0]           event_count_o,
  output logic [15:0]           drop_count_o,
  output logic [15:0]           err_count_o
);

  state_t state, state_next;

  logic [EVLEN_BITS-1:0] len_q, rem_q;
  logic [31:0] ip_q, evnum_q, event_count_q;
  logic [15:0] port_q, mask_q, frag_idx_q, drop_count_q, err_count_q;
  logic [9:0]  nfrag_q;
  logic        open_q, last_q, drop_err_q;
  logic [13:0] maxb_q, fbytes_q;
  logic [10:0] fwords_q, word_cnt_q;

  logic [13:0] calc_maxb, calc_fbytes;
  logic [10:0] calc_fwords;
  logic        calc_last;

  logic evlen_hs, hdr_hs, data_hs, drop_hs;
  logic frag_end, event_end;

  turf_frag_calc #(.EVLEN_BITS(EVLEN_BITS)) u_calc (
    .rem_bytes (rem_q),
    .nfrag     (nfrag_q),
    .maxb      (calc_maxb),
    .fbytes    (calc_fbytes),
    .fwords    (calc_fwords),
    .last      (calc_last)
  );

  assign evlen_hs  = (state == ST_IDLE) && s_evlen_tvalid;
  assign hdr_hs    = (state == ST_HDR) && m_udphdr_tready;
  assign data_hs   = (state == ST_DATA) && s_evdata_tvalid && m_udpdata_tready;
  assign drop_hs   = (state == ST_DROP) && s_evdata_tvalid && s_evdata_tlast;
  assign frag_end  = (word_cnt_q == fwords_q - 11'd1);
  assign event_end = last_q && frag_end;

  always_ff @(posedge aclk) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (s_evlen_tvalid) state_next = ST_CHECK;
      ST_CHECK: state_next = (!open_q || len_q == '0) ? ST_DROP : ST_CALC;
      ST_CALC:  state_next = ST_HDR;
      ST_HDR:   if (hdr_hs) state_next = ST_FHDR;
      ST_FHDR:  if (m_udpdata_tready) state_next = ST_DATA;
      ST_DATA: begin
        // an input tlast always ends the event, early or not
        if (data_hs) begin
          if (s_evdata_tlast) state_next = ST_IDLE;
          else if (event_end) state_next = ST_DROP;
          else if (frag_end)  state_next = ST_CALC;
        end
      end
      ST_DROP:  if (drop_hs) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_evlen_tready   = (state == ST_IDLE) && !areset;
    s_evdata_tready  = 1'b0;
    m_udphdr_tvalid  = (state == ST_HDR);
    m_udphdr_tdata   = udp_hdr_word(ip_q, port_q,
                                    16'(fbytes_q) + 16'(UDP_HDR_BYTES + FRAG_HDR_BYTES));
    m_udpdata_tvalid = 1'b0;
    m_udpdata_tdata  = frag_hdr_word(evnum_q, frag_idx_q,
                                     (frag_idx_q == '0) ? mask_q : {15'd0, last_q});
    m_udpdata_tkeep  = 8'hFF;
    m_udpdata_tlast  = 1'b0;
    unique case (state)
      ST_FHDR: m_udpdata_tvalid = 1'b1;
      ST_DATA: begin
        s_evdata_tready  = m_udpdata_tready;
        m_udpdata_tvalid = s_evdata_tvalid;
        m_udpdata_tdata  = s_evdata_tdata;
        m_udpdata_tkeep  = (event_end || s_evdata_tlast) ? s_evdata_tkeep : 8'hFF;
        m_udpdata_tlast  = frag_end || s_evdata_tlast;
      end
      ST_DROP: s_evdata_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      len_q <= '0; rem_q <= '0; ip_q <= '0; port_q <= '0; mask_q <= '0;
      nfrag_q <= '0; open_q <= 1'b0; last_q <= 1'b0; drop_err_q <= 1'b0;
      maxb_q <= '0; fbytes_q <= '0; fwords_q <= '0; word_cnt_q <= '0;
      frag_idx_q <= '0; evnum_q <= '0;
      event_count_q <= '0; drop_count_q <= '0; err_count_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (evlen_hs) begin
          len_q   <= s_evlen_tdata;
          ip_q    <= event_ip_i;
          port_q  <= event_port_i;
          open_q  <= event_open_i;
          nfrag_q <= nfragment_count_i;
          mask_q  <= fragsrc_mask_i;
        end
        ST_CHECK: begin
          rem_q      <= len_q;
          frag_idx_q <= '0;
          drop_err_q <= (len_q == '0);
          if (len_q == '0 && err_count_q != '1) err_count_q <= err_count_q + 16'd1;
        end
        ST_CALC: begin
          maxb_q     <= calc_maxb;
          fbytes_q   <= calc_fbytes;
          fwords_q   <= calc_fwords;
          last_q     <= calc_last;
          word_cnt_q <= '0;
        end
        ST_DATA: if (data_hs) begin
          word_cnt_q <= word_cnt_q + 11'd1;
          if (s_evdata_tlast || event_end) evnum_q <= evnum_q + 32'd1;
          if (s_evdata_tlast && event_end) begin
            if (event_count_q != '1) event_count_q <= event_count_q + 32'd1;
          end else if (s_evdata_tlast || event_end) begin
            if (err_count_q != '1) err_count_q <= err_count_q + 16'd1;
            if (!s_evdata_tlast) drop_err_q <= 1'b1;
          end else if (frag_end) begin
            rem_q      <= rem_q - EVLEN_BITS'(maxb_q);
            frag_idx_q <= frag_idx_q + 16'd1;
          end
        end
        ST_DROP: if (drop_hs && !drop_err_q && drop_count_q != '1)
          drop_count_q <= drop_count_q + 16'd1;
        default: ;
      endcase
    end
  end

  assign event_count_o = event_count_q;
  assign drop_count_o  = drop_count_q;
  assign err_count_o   = err_count_q;

  generate
    if (DEBUG == "TRUE") begin : g_debug
      // registered probes for an ILA on the handshakes and state
      (* mark_debug = "true" *) logic [2:0] dbg_state;
      (* mark_debug = "true" *) logic [3:0] dbg_hs;
      always_ff @(posedge aclk) begin
        dbg_state <= state;
        dbg_hs    <= {evlen_hs, hdr_hs, data_hs, drop_hs};
      end
    end
  endgenerate

endmodule

// File: tb/tb_turf_event_fragmenter.sv
// Directed bench for turf_event_fragmenter: fragmentation, drop, length mismatch,
// stalled output and mid-event close cases against hand-computed results.
module tb_turf_event_fragmenter;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        areset;
  logic [19:0] s_evlen_tdata;
  logic        s_evlen_tvalid, s_evlen_tready;
  logic [63:0] s_evdata_tdata;
  logic [7:0]  s_evdata_tkeep;
  logic        s_evdata_tlast, s_evdata_tvalid, s_evdata_tready;
  logic [63:0] m_udphdr_tdata;
  logic        m_udphdr_tvalid, m_udphdr_tready;
  logic [63:0] m_udpdata_tdata;
  logic [7:0]  m_udpdata_tkeep;
  logic        m_udpdata_tlast, m_udpdata_tvalid, m_udpdata_tready;
  logic [9:0]  nfragment_count_i;
  logic [15:0] fragsrc_mask_i, event_port_i;
  logic [31:0] event_ip_i, event_count_o;
  logic        event_open_i;
  logic [15:0] drop_count_o, err_count_o;

  int checks = 0;
  int errors = 0;
  bit stall = 1'b0;

  logic [63:0] hdr_q[$];
  logic [63:0] dat_q[$];
  logic [7:0]  keep_q[$];
  logic        last_q[$];
  int consumed = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int hdr_lat = -1;
  bit wait_hdr = 1'b0;

  localparam logic [31:0] IP   = 32'h0A000001;
  localparam logic [15:0] PORT = 16'h1234;

  turf_event_fragmenter #(.EVLEN_BITS(20), .DEBUG("FALSE")) dut (
    .aclk              (aclk),
    .areset            (areset),
    .s_evlen_tdata     (s_evlen_tdata),
    .s_evlen_tvalid    (s_evlen_tvalid),
    .s_evlen_tready    (s_evlen_tready),
    .s_evdata_tdata    (s_evdata_tdata),
    .s_evdata_tkeep    (s_evdata_tkeep),
    .s_evdata_tlast    (s_evdata_tlast),
    .s_evdata_tvalid   (s_evdata_tvalid),
    .s_evdata_tready   (s_evdata_tready),
    .m_udphdr_tdata    (m_udphdr_tdata),
    .m_udphdr_tvalid   (m_udphdr_tvalid),
    .m_udphdr_tready   (m_udphdr_tready),
    .m_udpdata_tdata   (m_udpdata_tdata),
    .m_udpdata_tkeep   (m_udpdata_tkeep),
    .m_udpdata_tlast   (m_udpdata_tlast),
    .m_udpdata_tvalid  (m_udpdata_tvalid),
    .m_udpdata_tready  (m_udpdata_tready),
    .nfragment_count_i (nfragment_count_i),
    .fragsrc_mask_i    (fragsrc_mask_i),
    .event_ip_i        (event_ip_i),
    .event_port_i      (event_port_i),
    .event_open_i      (event_open_i),
    .event_count_o     (event_count_o),
    .drop_count_o      (drop_count_o),
    .err_count_o       (err_count_o)
  );

  // Downstream readiness changes just after each rising edge.
  always @(posedge aclk) begin
    #1;
    m_udphdr_tready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    m_udpdata_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Record every handshake on the falling edge, when all signals are settled.
  always @(negedge aclk) begin
    cyc++;
    if (m_udphdr_tvalid && m_udphdr_tready) hdr_q.push_back(m_udphdr_tdata);
    if (m_udpdata_tvalid && m_udpdata_tready) begin
      dat_q.push_back(m_udpdata_tdata);
      keep_q.push_back(m_udpdata_tkeep);
      last_q.push_back(m_udpdata_tlast);
    end
    if (s_evdata_tvalid && s_evdata_tready) consumed++;
    if (s_evlen_tvalid && s_evlen_tready) begin
      hs_cyc   = cyc;
      wait_hdr = 1'b1;
    end else if (wait_hdr && m_udphdr_tvalid) begin
      hdr_lat  = cyc - hs_cyc;
      wait_hdr = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] pat(input logic [7:0] ev, input int i);
    return {8'hA5, ev, 16'h0000, 32'(i)};
  endfunction

  function automatic logic [63:0] geth(input int idx);
    return (idx < hdr_q.size()) ? hdr_q[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] getd(input int idx);
    return (idx < dat_q.size()) ? dat_q[idx] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [7:0] getk(input int idx);
    return (idx < keep_q.size()) ? keep_q[idx] : 8'h00;
  endfunction

  function automatic logic getl(input int idx);
    return (idx < last_q.size()) ? last_q[idx] : 1'b0;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one length beat then nwords payload words, tlast on the final one.
  task automatic apply_stimulus(input logic [19:0] len, input int nwords, input logic [7:0] ev,
                                input logic [7:0] last_keep, input bit close_after);
    int t;
    s_evlen_tdata  = len;
    s_evlen_tvalid = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (!s_evlen_tready && t < 1000);
    check_output("evlen_handshake", 64'(s_evlen_tready), 64'd1);
    @(posedge aclk); #1;
    s_evlen_tvalid = 1'b0;
    if (close_after) event_open_i = 1'b0;
    for (int i = 0; i < nwords; i++) begin
      s_evdata_tdata  = pat(ev, i);
      s_evdata_tkeep  = (i == nwords - 1) ? last_keep : 8'hFF;
      s_evdata_tlast  = (i == nwords - 1);
      s_evdata_tvalid = 1'b1;
      t = 0;
      do begin @(negedge aclk); t++; end while (!s_evdata_tready && t < 2000);
      @(posedge aclk); #1;
      if (t >= 2000) begin
        check_output("evdata_timeout", 64'(t), 64'd0);
        break;
      end
    end
    s_evdata_tvalid = 1'b0;
    s_evdata_tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
  endtask

  initial begin
    int hb, db, cb, mism, lasts, pos, nw;
    logic [15:0] flags;

    areset = 1'b1;
    s_evlen_tdata = '0; s_evlen_tvalid = 1'b0;
    s_evdata_tdata = '0; s_evdata_tkeep = '0; s_evdata_tlast = 1'b0; s_evdata_tvalid = 1'b0;
    nfragment_count_i = 10'd127;
    fragsrc_mask_i    = 16'hBEEF;
    event_ip_i        = IP;
    event_port_i      = PORT;
    event_open_i      = 1'b1;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_output("rst_evlen_tready", 64'(s_evlen_tready), 64'd0);
    check_output("rst_evdata_tready", 64'(s_evdata_tready), 64'd0);
    check_output("rst_hdr_tvalid", 64'(m_udphdr_tvalid), 64'd0);
    check_output("rst_data_tvalid", 64'(m_udpdata_tvalid), 64'd0);
    check_output("rst_counters", {event_count_o, drop_count_o, err_count_o}, 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check_output("idle_evlen_tready", 64'(s_evlen_tready), 64'd1);
    @(posedge aclk); #1;

    $display("[TB] two full fragments, len=2048 nfrag=127");
    hb = hdr_q.size(); db = dat_q.size();
    apply_stimulus(20'd2048, 256, 8'h01, 8'hFF, 1'b0);
    check_output("t1_hdr_count", 64'(hdr_q.size() - hb), 64'd2);
    check_output("t1_hdr0", geth(hb), {IP, PORT, 16'd1040});
    check_output("t1_hdr1", geth(hb + 1), {IP, PORT, 16'd1040});
    check_output("t1_latency", 64'(hdr_lat), 64'd3);
    check_output("t1_data_count", 64'(dat_q.size() - db), 64'd258);
    check_output("t1_fhdr0", getd(db), {32'd0, 16'd0, 16'hBEEF});
    check_output("t1_fhdr1", getd(db + 129), {32'd0, 16'd1, 16'd1});
    check_output("t1_tlast_f0", 64'(getl(db + 128)), 64'd1);
    check_output("t1_tlast_f1", 64'(getl(db + 257)), 64'd1);
    mism = 0; lasts = 0;
    for (int i = 0; i < 256; i++) begin
      pos = db + ((i < 128) ? 1 + i : 2 + i);
      if (getd(pos) !== pat(8'h01, i)) mism++;
    end
    for (int i = db; i < dat_q.size(); i++) if (last_q[i]) lasts++;
    check_output("t1_payload", 64'(mism), 64'd0);
    check_output("t1_tlast_total", 64'(lasts), 64'd2);
    check_output("t1_event_count", 64'(event_count_o), 64'd1);

    $display("[TB] short tail fragment, len=1029");
    hb = hdr_q.size(); db = dat_q.size();
    apply_stimulus(20'd1029, 129, 8'h02, 8'h1F, 1'b0);
    check_output("t2_hdr0", geth(hb), {IP, PORT, 16'd1040});
    check_output("t2_hdr1", geth(hb + 1), {IP, PORT, 16'd21});
    check_output("t2_data_count", 64'(dat_q.size() - db), 64'd131);
    check_output("t2_fhdr1", getd(db + 129), {32'd1, 16'd1, 16'd1});
    check_output("t2_tail_data", getd(db + 130), pat(8'h02, 128));
    check_output("t2_tail_keep", 64'(getk(db + 130)), 64'h1F);
    check_output("t2_tail_last", 64'(getl(db + 130)), 64'd1);
    check_output("t2_event_count", 64'(event_count_o), 64'd2);

    $display("[TB] closed destination drops the event");
    event_open_i = 1'b0;
    hb = hdr_q.size(); db = dat_q.size(); cb = consumed;
    apply_stimulus(20'd32, 4, 8'h03, 8'hFF, 1'b0);
    check_output("t3_hdr_count", 64'(hdr_q.size() - hb), 64'd0);
    check_output("t3_data_count", 64'(dat_q.size() - db), 64'd0);
    check_output("t3_consumed", 64'(consumed - cb), 64'd4);
    check_output("t3_drop_count", 64'(drop_count_o), 64'd1);

    $display("[TB] early input tlast, len=64 with 5 words");
    event_open_i = 1'b1;
    hb = hdr_q.size(); db = dat_q.size();
    apply_stimulus(20'd64, 5, 8'h04, 8'hFF, 1'b0);
    check_output("t4_hdr", geth(hb), {IP, PORT, 16'd80});
    check_output("t4_data_count", 64'(dat_q.size() - db), 64'd6);
    check_output("t4_fhdr", getd(db), {32'd2, 16'd0, 16'hBEEF});
    check_output("t4_tlast_w5", 64'(getl(db + 5)), 64'd1);
    check_output("t4_tlast_w4", 64'(getl(db + 4)), 64'd0);
    check_output("t4_err_count", 64'(err_count_o), 64'd1);
    hb = hdr_q.size(); db = dat_q.size();
    apply_stimulus(20'd16, 2, 8'h05, 8'hFF, 1'b0);
    check_output("t4_next_hdr", geth(hb), {IP, PORT, 16'd32});
    check_output("t4_next_fhdr", getd(db), {32'd3, 16'd0, 16'hBEEF});
    check_output("t4_next_event_count", 64'(event_count_o), 64'd3);

    $display("[TB] 3000-byte event, nfrag=31, random output stalls");
    nfragment_count_i = 10'd31;
    fragsrc_mask_i    = 16'h00C3;
    stall = 1'b1;
    hb = hdr_q.size(); db = dat_q.size();
    apply_stimulus(20'd3000, 375, 8'h06, 8'hFF, 1'b0);
    stall = 1'b0;
    check_output("t5_hdr_count", 64'(hdr_q.size() - hb), 64'd12);
    check_output("t5_hdr_last", geth(hb + 11), {IP, PORT, 16'd200});
    check_output("t5_data_count", 64'(dat_q.size() - db), 64'd387);
    mism = 0; pos = db; nw = 0;
    for (int f = 0; f < 12; f++) begin
      if (f < 11 && geth(hb + f) !== {IP, PORT, 16'd272}) mism++;
      flags = (f == 0) ? 16'h00C3 : {15'd0, (f == 11)};
      if (getd(pos) !== {32'd4, 16'(f), flags}) mism++;
      if (getl(pos)) mism++;
      pos++;
      for (int w = 0; w < ((f < 11) ? 32 : 23); w++) begin
        if (getd(pos) !== pat(8'h06, nw)) mism++;
        if (getl(pos) !== (w == ((f < 11) ? 31 : 22))) mism++;
        pos++; nw++;
      end
    end
    check_output("t5_stream", 64'(mism), 64'd0);
    check_output("t5_event_count", 64'(event_count_o), 64'd4);

    $display("[TB] destination closes during an event");
    nfragment_count_i = 10'd7;
    fragsrc_mask_i    = 16'hBEEF;
    hb = hdr_q.size(); db = dat_q.size();
    apply_stimulus(20'd256, 32, 8'h07, 8'hFF, 1'b1);
    check_output("t6_hdr_count", 64'(hdr_q.size() - hb), 64'd4);
    check_output("t6_hdr3", geth(hb + 3), {IP, PORT, 16'd80});
    check_output("t6_data_count", 64'(dat_q.size() - db), 64'd36);
    check_output("t6_event_count", 64'(event_count_o), 64'd5);
    hb = hdr_q.size();
    apply_stimulus(20'd16, 2, 8'h08, 8'hFF, 1'b0);
    check_output("t6_next_hdr_count", 64'(hdr_q.size() - hb), 64'd0);
    check_output("t6_next_drop_count", 64'(drop_count_o), 64'd2);

    $display("[TB] missing input tlast, len=16 with 3 words");
    event_open_i      = 1'b1;
    nfragment_count_i = 10'd127;
    hb = hdr_q.size(); db = dat_q.size(); cb = consumed;
    apply_stimulus(20'd16, 3, 8'h09, 8'hFF, 1'b0);
    check_output("t7_hdr", geth(hb), {IP, PORT, 16'd32});
    check_output("t7_fhdr", getd(db), {32'd6, 16'd0, 16'hBEEF});
    check_output("t7_data_count", 64'(dat_q.size() - db), 64'd3);
    check_output("t7_tlast", 64'(getl(db + 2)), 64'd1);
    check_output("t7_consumed", 64'(consumed - cb), 64'd3);
    check_output("t7_err_count", 64'(err_count_o), 64'd2);
    check_output("t7_drop_count", 64'(drop_count_o), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
